exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute controller for the 8-bit core. Sequences flash, program_counter,
//  register_file and alu so LB, SB and ADD run without bench-driven stepping. Sits above those blocks.
//  control_unit decodes ir combinationally into imm/rs1/rs2/rd/alu_op and feeds them back here.
// PARAMETERS
//  ADDR_W        24  flash address / PC width
//  FLASH_RD_LAT  2   cycles from the re+addr sample edge to flash_out valid (>=1)
// PORTS
//  clk          in   1       system clock (from clock block)
//  reset        in   1       synchronous, active-high
//  run          in   1       1 = fetch next instruction when idle
//  pc_out       in   ADDR_W  current PC from program_counter
//  pc_control   out  2       00 hold, 01 increment; no other codes driven
//  flash_re     out  1       flash read enable
//  flash_we     out  1       flash write enable
//  flash_addr   out  ADDR_W  flash address
//  flash_in     out  8       flash write data
//  flash_out    in   8       flash read data
//  ir           out  32      fetched instruction, to control_unit
//  imm          in   32      decoded immediate
//  rd           in   5       decoded destination register index
//  reg_we       out  1       register_file write enable
//  wd           out  8       register_file write data
//  rd1, rd2     in   8       register_file read ports (rs1, rs2)
//  alu_a, alu_b out  8       ALU operands
//  alu_result   in   8       ALU result (carry ignored)
//  busy         out  1       high in any state except IDLE/HALT
//  instr_done   out  1       1-cycle pulse when an instruction retires
//  illegal      out  1       sticky; unsupported instruction seen
//  instr_count  out  16      retired-instruction count, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (any state, incl. mid-fetch/store): all outputs 0, ir=0, state IDLE next edge; a pending store is dropped.
//  States: IDLE, F_REQ, F_WAIT, F_CAP, DECODE, M_REQ, M_WAIT, M_WB, ALU_X, ALU_WB, STORE, HALT.
//  IDLE: run=1 -> F_REQ, byte index=0; else stay.
//  Fetch byte: F_REQ re=1, addr=pc_out (1 cyc); F_WAIT FLASH_RD_LAT-1 cyc; F_CAP latches flash_out into
//    ir[8*i+:8] and drives pc_control=01 for 1 cyc. i<3 -> F_REQ, else DECODE.
//    Little-endian; fetch = 4*(FLASH_RD_LAT+1) cycles; PC ends at next instruction.
//  DECODE (1 cyc, re=0):
//    op=0000011,f3=000 -> M_REQ; op=0110011,f3=000,f7=0 -> ALU_X;
//    op=0100011,f3=000 -> STORE; else illegal=1 -> HALT.
//  EA = ({16'b0,rd1} + imm[23:0]) mod 2^24.
//  LB: M_REQ re=1, addr=EA; M_WAIT FLASH_RD_LAT-1 cyc; M_WB reg_we=1, wd=flash_out (1 cyc).
//  ADD: ALU_X alu_a=rd1, alu_b=rd2; ALU_WB operands held, reg_we=1, wd=alu_result (1 cyc); 8-bit wrap.
//  SB: STORE we=1, re=0, addr=EA, flash_in=rd2 for exactly 1 cyc.
//  rd==0: reg_we suppressed; instruction still retires.
//  Retire (last exec cyc +1): instr_done=1, instr_count+1; next state F_REQ if run=1 else IDLE.
//    run dropping mid-instruction never aborts it.
//  HALT: busy=0, no flash/reg activity until reset.
//  re and we never both high; pc_control=01 only in F_CAP. Unused outputs hold 0 outside their states.
// TESTING (FLASH_RD_LAT=2)
//  flash[0..3]=83 02 00 02 (lb t0,32(x0)), flash[0x20]=0x0A, run=1 -> exactly one reg_we, rd=5, wd=0x0A;
//    instr_done 12+1+2+1 cycles after run; pc_out=4.
//  Program lb t0,32; lb t1,33; add t2,t0,t1; sb t2,34(x0), flash[0x21]=0x5A
//    -> flash[0x22]=0x64; instr_count=4; illegal=0.
//  ADD with t0=0xF0, t1=0x20 -> wd=0x10 to rd=7.
//  ir=0x00000000 -> illegal=1, HALT, busy=0; no further re/we/pc_control for 20 cycles.
//  reset=1 during byte 2 of fetch and during STORE cycle -> all outputs 0 next edge; no flash write occurs.
//  lb x0,32(x0) -> reg_we never asserted; instr_done pulses; run=0 before retire -> IDLE after retire.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
//   Bundles the buses between the fetch/decode/execute sequencer and the
//   blocks it drives: program_counter, flash, control_unit, register_file and
//   alu.
//   master modport : sequencer side (drives pc_control, flash strobes/address/
//                    write data, ir, reg_we/wd, alu operands)
//   slave modport  : datapath side (drives pc_out, flash_out, decoded imm/rd,
//                    register read ports rd1/rd2, alu_result)
interface exec_sequencer_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] pc_out;
    logic [1:0]        pc_control;
    logic              flash_re;
    logic              flash_we;
    logic [ADDR_W-1:0] flash_addr;
    logic [7:0]        flash_in;
    logic [7:0]        flash_out;
    logic [31:0]       ir;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic              reg_we;
    logic [7:0]        wd;
    logic [7:0]        rd1;
    logic [7:0]        rd2;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [7:0]        alu_result;

    modport master (
        input  pc_out, flash_out, imm, rd, rd1, rd2, alu_result,
        output pc_control, flash_re, flash_we, flash_addr, flash_in,
               ir, reg_we, wd, alu_a, alu_b
    );

    modport slave (
        output pc_out, flash_out, imm, rd, rd1, rd2, alu_result,
        input  pc_control, flash_re, flash_we, flash_addr, flash_in,
               ir, reg_we, wd, alu_a, alu_b
    );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle fetch/decode/execute controller for the 8-bit core. Fetches a
//   32-bit instruction one byte at a time from flash (little-endian), lets
//   control_unit decode it, then runs LB, SB or ADD; anything else halts.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     run          : start fetching when idle / keep fetching after retire
//     bus          : exec_sequencer_if.master (pc, flash, ir/decode, regfile, alu)
//     busy         : high in every state except IDLE and HALT
//     instr_done   : one-cycle pulse the cycle after an instruction's last step
//     illegal      : sticky, set when an unsupported instruction is decoded
//     instr_count  : retired-instruction count, wraps at 16 bits
module exec_sequencer #(
    parameter int ADDR_W       = 24,
    parameter int FLASH_RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    exec_sequencer_if.master    bus,
    output logic                busy,
    output logic                instr_done,
    output logic                illegal,
    output logic [15:0]         instr_count
);

    typedef enum logic [3:0] {
        IDLE, F_REQ, F_WAIT, F_CAP, DECODE, M_REQ,
        M_WAIT, M_WB, ALU_X, ALU_WB, STORE, HALT
    } state_t;

    // Last value of the wait counter before the capture/write-back state.
    localparam logic [7:0] WAIT_LAST = 8'(FLASH_RD_LAT - 2);

    state_t            state, state_d;
    logic [1:0]        byte_idx;
    logic [7:0]        wait_cnt;
    logic [31:0]       ir_q;
    logic              retire;
    logic              set_illegal;
    logic [ADDR_W-1:0] ea;

    logic unused_imm;
    assign unused_imm = ^bus.imm[31:ADDR_W];

    assign bus.ir = ir_q;
    assign busy   = (state != IDLE) && (state != HALT);
    assign ea     = {{(ADDR_W-8){1'b0}}, bus.rd1} + bus.imm[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_idx    <= 2'd0;
            wait_cnt    <= 8'd0;
            ir_q        <= 32'd0;
            instr_done  <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            state      <= state_d;
            instr_done <= retire;
            if (retire)
                instr_count <= instr_count + 16'd1;
            if (set_illegal)
                illegal <= 1'b1;
            // byte_idx wraps 3 -> 0 on the last capture, so every fetch starts at byte 0
            if (state == F_CAP) begin
                ir_q[8*byte_idx +: 8] <= bus.flash_out;
                byte_idx              <= byte_idx + 2'd1;
            end
            if (state == F_WAIT || state == M_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        state_d     = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            IDLE:   if (run) state_d = F_REQ;
            F_REQ:  state_d = (FLASH_RD_LAT > 1) ? F_WAIT : F_CAP;
            F_WAIT: if (wait_cnt == WAIT_LAST) state_d = F_CAP;
            F_CAP:  state_d = (byte_idx == 2'd3) ? DECODE : F_REQ;
            DECODE: begin
                if (ir_q[6:0] == 7'b0000011 && ir_q[14:12] == 3'b000)
                    state_d = M_REQ;
                else if (ir_q[6:0] == 7'b0110011 && ir_q[14:12] == 3'b000 &&
                         ir_q[31:25] == 7'b0000000)
                    state_d = ALU_X;
                else if (ir_q[6:0] == 7'b0100011 && ir_q[14:12] == 3'b000)
                    state_d = STORE;
                else begin
                    set_illegal = 1'b1;
                    state_d     = HALT;
                end
            end
            M_REQ:  state_d = (FLASH_RD_LAT > 1) ? M_WAIT : M_WB;
            M_WAIT: if (wait_cnt == WAIT_LAST) state_d = M_WB;
            ALU_X:  state_d = ALU_WB;
            M_WB, ALU_WB, STORE: begin
                // run is only consulted here, so dropping it never aborts an instruction
                retire  = 1'b1;
                state_d = run ? F_REQ : IDLE;
            end
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Write strobes are masked by reset in the same cycle so a store or
    // register write in flight when reset arrives never lands.
    always_comb begin
        bus.pc_control = 2'b00;
        bus.flash_re   = 1'b0;
        bus.flash_we   = 1'b0;
        bus.flash_addr = '0;
        bus.flash_in   = 8'd0;
        bus.reg_we     = 1'b0;
        bus.wd         = 8'd0;
        bus.alu_a      = 8'd0;
        bus.alu_b      = 8'd0;
        case (state)
            F_REQ: begin
                bus.flash_re   = 1'b1;
                bus.flash_addr = bus.pc_out;
            end
            F_CAP: bus.pc_control = 2'b01;
            M_REQ: begin
                bus.flash_re   = 1'b1;
                bus.flash_addr = ea;
            end
            M_WB: begin
                bus.reg_we = (bus.rd != 5'd0) && !reset;
                bus.wd     = bus.flash_out;
            end
            ALU_X: begin
                bus.alu_a = bus.rd1;
                bus.alu_b = bus.rd2;
            end
            ALU_WB: begin
                bus.alu_a  = bus.rd1;
                bus.alu_b  = bus.rd2;
                bus.reg_we = (bus.rd != 5'd0) && !reset;
                bus.wd     = bus.alu_result;
            end
            STORE: begin
                bus.flash_we   = !reset;
                bus.flash_addr = ea;
                bus.flash_in   = bus.rd2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
//   Directed bench for exec_sequencer with FLASH_RD_LAT=2. Surrounds the
//   sequencer with small behavioural models of flash (two-stage read pipe),
//   program_counter, control_unit decode, register_file and alu.
module tb_exec_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        busy;
    logic        instr_done;
    logic        illegal;
    logic [15:0] instr_count;

    exec_sequencer_if #(.ADDR_W(24)) bus ();

    exec_sequencer #(.ADDR_W(24), .FLASH_RD_LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .bus        (bus),
        .busy       (busy),
        .instr_done (instr_done),
        .illegal    (illegal),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    // ---------------- datapath models ----------------
    logic [7:0]  mem [256];
    logic [7:0]  rd_p1;
    logic        ld_en, ld_clr;
    logic [7:0]  ld_addr, ld_data;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.flash_we) begin
            mem[bus.flash_addr[7:0]] <= bus.flash_in;
            wr_cnt <= wr_cnt + 1;
        end
        rd_p1         <= bus.flash_re ? mem[bus.flash_addr[7:0]] : 8'h00;
        bus.flash_out <= rd_p1;
    end

    logic [23:0] pc;
    always @(posedge clk) begin
        if (reset) pc <= 24'd0;
        else if (bus.pc_control == 2'b01) pc <= pc + 24'd1;
    end
    assign bus.pc_out = pc;

    logic [7:0] regs [32];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
        end else if (bus.reg_we) begin
            regs[bus.rd] <= bus.wd;
        end
    end

    logic [4:0] rs1, rs2;
    assign rs1            = bus.ir[19:15];
    assign rs2            = bus.ir[24:20];
    assign bus.rd         = bus.ir[11:7];
    assign bus.imm        = (bus.ir[6:0] == 7'b0100011) ?
                            {{20{bus.ir[31]}}, bus.ir[31:25], bus.ir[11:7]} :
                            {{20{bus.ir[31]}}, bus.ir[31:20]};
    assign bus.rd1        = (rs1 == 5'd0) ? 8'h00 : regs[rs1];
    assign bus.rd2        = (rs2 == 5'd0) ? 8'h00 : regs[rs2];
    assign bus.alu_result = bus.alu_a + bus.alu_b;

    // ---------------- activity monitor ----------------
    int         cnt_re = 0, cnt_we = 0, cnt_pcc = 0, cnt_regwe = 0, cnt_both = 0;
    logic [4:0] last_rd = 5'd0;
    logic [7:0] last_wd = 8'h00;
    logic [7:0] add_wd  = 8'h00;

    always @(negedge clk) begin
        if (bus.flash_re) cnt_re++;
        if (bus.flash_we) cnt_we++;
        if (bus.pc_control != 2'b00) cnt_pcc++;
        if (bus.flash_re && bus.flash_we) cnt_both++;
        if (bus.reg_we) begin
            cnt_regwe++;
            last_rd = bus.rd;
            last_wd = bus.wd;
            if (bus.rd == 5'd7) add_wd = bus.wd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold_reset();
        @(negedge clk);
        reset  = 1'b1;
        run    = 1'b0;
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hold_reset();
        @(negedge clk);
        nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL reset_busy: got %b want 0", busy); end
        nchecks++; if (instr_count !== 16'd0) begin nerrors++; $display("FAIL reset_count: got %h want 0000", instr_count); end
        nchecks++; if (illegal !== 1'b0 || instr_done !== 1'b0) begin nerrors++; $display("FAIL reset_flags: got illegal=%b done=%b want 0 0", illegal, instr_done); end
        nchecks++; if ({bus.flash_re, bus.flash_we, bus.reg_we, bus.pc_control} !== 5'b0) begin nerrors++; $display("FAIL reset_strobes: got %b want 00000", {bus.flash_re, bus.flash_we, bus.reg_we, bus.pc_control}); end
        nchecks++; if (bus.ir !== 32'h0) begin nerrors++; $display("FAIL reset_ir: got %h want 00000000", bus.ir); end
        release_reset();
        @(negedge clk);
        nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL idle_no_run: busy got %b want 0", busy); end
    endtask

    task automatic test_lb();
        int n; bit seen; int r0;
        hold_reset();
        load(8'h00, 8'h83); load(8'h01, 8'h02); load(8'h02, 8'h00); load(8'h03, 8'h02);
        load(8'h20, 8'h0A);
        release_reset();
        r0 = cnt_regwe;
        run = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) run = 1'b0;
            if (instr_done === 1'b1) seen = 1;
        end
        // instr_done rises 16 clocks after the edge that sampled run (17th negedge)
        nchecks++; if (n != 17) begin nerrors++; $display("FAIL lb_latency: got %0d negedges want 17", n); end
        nchecks++; if (cnt_regwe - r0 != 1) begin nerrors++; $display("FAIL lb_regwe_count: got %0d want 1", cnt_regwe - r0); end
        nchecks++; if (last_rd !== 5'd5 || last_wd !== 8'h0A) begin nerrors++; $display("FAIL lb_write: got rd=%0d wd=%h want rd=5 wd=0a", last_rd, last_wd); end
        nchecks++; if (pc !== 24'd4) begin nerrors++; $display("FAIL lb_pc: got %0d want 4", pc); end
        nchecks++; if (instr_count !== 16'd1) begin nerrors++; $display("FAIL lb_count: got %0d want 1", instr_count); end
        nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL lb_idle_after: busy got %b want 0", busy); end
        @(negedge clk);
        nchecks++; if (instr_done !== 1'b0) begin nerrors++; $display("FAIL lb_done_pulse: got %b want 0", instr_done); end
    endtask

    task automatic test_program(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] sum, input string tag);
        int n; int b0;
        logic [7:0] prog [16];
        prog = '{8'h83, 8'h02, 8'h00, 8'h02,   // lb  t0,32(x0)
                 8'h03, 8'h03, 8'h10, 8'h02,   // lb  t1,33(x0)
                 8'hB3, 8'h83, 8'h62, 8'h00,   // add t2,t0,t1
                 8'h23, 8'h01, 8'h70, 8'h02};  // sb  t2,34(x0)
        hold_reset();
        for (int i = 0; i < 16; i++) load(8'(i), prog[i]);
        load(8'h20, d0);
        load(8'h21, d1);
        release_reset();
        b0 = cnt_both;
        run = 1'b1;
        n = 0;
        while (instr_count < 16'd3 && n < 200) begin @(negedge clk); n++; end
        run = 1'b0;
        while (instr_count < 16'd4 && n < 260) begin @(negedge clk); n++; end
        @(negedge clk);
        nchecks++; if (mem[8'h22] !== sum) begin nerrors++; $display("FAIL %s_store: got %h want %h", tag, mem[8'h22], sum); end
        nchecks++; if (add_wd !== sum || regs[7] !== sum) begin nerrors++; $display("FAIL %s_add: got wd=%h x7=%h want %h", tag, add_wd, regs[7], sum); end
        nchecks++; if (instr_count !== 16'd4 || illegal !== 1'b0) begin nerrors++; $display("FAIL %s_count: got count=%0d illegal=%b want 4 0", tag, instr_count, illegal); end
        nchecks++; if (pc !== 24'd16 || busy !== 1'b0) begin nerrors++; $display("FAIL %s_end: got pc=%0d busy=%b want 16 0", tag, pc, busy); end
        nchecks++; if (cnt_both != b0) begin nerrors++; $display("FAIL %s_re_we: got %0d overlaps want 0", tag, cnt_both - b0); end
    endtask

    task automatic test_illegal();
        int n; bit seen; int re0, we0, pc0, rw0;
        hold_reset();
        release_reset();
        run = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (illegal === 1'b1) seen = 1;
        end
        nchecks++; if (!seen) begin nerrors++; $display("FAIL ill_flag: illegal got 0 after %0d cycles want 1", n); end
        nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL ill_busy: got %b want 0", busy); end
        re0 = cnt_re; we0 = cnt_we; pc0 = cnt_pcc; rw0 = cnt_regwe;
        repeat (20) @(negedge clk);
        nchecks++; if (cnt_re != re0 || cnt_we != we0 || cnt_pcc != pc0 || cnt_regwe != rw0) begin nerrors++; $display("FAIL ill_quiet: got re=%0d we=%0d pcc=%0d regwe=%0d want all 0", cnt_re - re0, cnt_we - we0, cnt_pcc - pc0, cnt_regwe - rw0); end
        nchecks++; if (illegal !== 1'b1 || busy !== 1'b0 || instr_count !== 16'd0) begin nerrors++; $display("FAIL ill_hold: got illegal=%b busy=%b count=%0d want 1 0 0", illegal, busy, instr_count); end
        run = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        hold_reset();
        load(8'h00, 8'h83); load(8'h01, 8'h02); load(8'h02, 8'h00); load(8'h03, 8'h02);
        release_reset();
        run = 1'b1;
        repeat (8) @(negedge clk);   // waiting on byte 2
        nchecks++; if (busy !== 1'b1) begin nerrors++; $display("FAIL mf_busy_pre: got %b want 1", busy); end
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        nchecks++; if (busy !== 1'b0 || bus.flash_re !== 1'b0 || bus.pc_control !== 2'b00) begin nerrors++; $display("FAIL mf_outputs: got busy=%b re=%b pcc=%b want 0 0 00", busy, bus.flash_re, bus.pc_control); end
        nchecks++; if (bus.ir !== 32'h0) begin nerrors++; $display("FAIL mf_ir: got %h want 00000000", bus.ir); end
        release_reset();
        @(negedge clk);
        nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL mf_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_store();
        int w0;
        hold_reset();
        load(8'h00, 8'h23); load(8'h01, 8'h01); load(8'h02, 8'h00); load(8'h03, 8'h02);   // sb x0,34(x0)
        load(8'h22, 8'hAA);
        release_reset();
        w0  = wr_cnt;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (13) @(negedge clk);  // STORE cycle
        nchecks++; if (bus.flash_we !== 1'b1 || bus.flash_addr !== 24'h000022) begin nerrors++; $display("FAIL st_strobe: got we=%b addr=%h want 1 000022", bus.flash_we, bus.flash_addr); end
        reset = 1'b1;
        @(negedge clk);
        nchecks++; if (bus.flash_we !== 1'b0 || busy !== 1'b0 || instr_done !== 1'b0 || instr_count !== 16'd0) begin nerrors++; $display("FAIL st_outputs: got we=%b busy=%b done=%b count=%0d want 0 0 0 0", bus.flash_we, busy, instr_done, instr_count); end
        release_reset();
        nchecks++; if (wr_cnt != w0 || mem[8'h22] !== 8'hAA) begin nerrors++; $display("FAIL st_dropped: got writes=%0d mem=%h want 0 aa", wr_cnt - w0, mem[8'h22]); end
    endtask

    task automatic test_lb_x0();
        int n; bit seen; int r0;
        hold_reset();
        load(8'h00, 8'h03); load(8'h01, 8'h00); load(8'h02, 8'h00); load(8'h03, 8'h02);   // lb x0,32(x0)
        load(8'h20, 8'h0A);
        release_reset();
        r0  = cnt_regwe;
        run = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk); n++;
            if (n == 1) run = 1'b0;
            if (instr_done === 1'b1) seen = 1;
        end
        nchecks++; if (!seen || n != 17) begin nerrors++; $display("FAIL x0_done: got seen=%b at %0d want 1 at 17", seen, n); end
        nchecks++; if (instr_count !== 16'd1) begin nerrors++; $display("FAIL x0_count: got %0d want 1", instr_count); end
        @(negedge clk);
        nchecks++; if (cnt_regwe != r0) begin nerrors++; $display("FAIL x0_regwe: got %0d writes want 0", cnt_regwe - r0); end
        nchecks++; if (busy !== 1'b0 || instr_done !== 1'b0) begin nerrors++; $display("FAIL x0_idle: got busy=%b done=%b want 0 0", busy, instr_done); end
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        ld_en   = 1'b0;
        ld_clr  = 1'b0;
        ld_addr = 8'h00;
        ld_data = 8'h00;
        test_reset();
        test_lb();
        test_program(8'h0A, 8'h5A, 8'h64, "prog");
        test_program(8'hF0, 8'h20, 8'h10, "addwrap");
        test_illegal();
        test_reset_midfetch();
        test_reset_store();
        test_lb_x0();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
